// File: rtl/try_pkg.sv
// Shared definitions for the P5 primary-opcode classifier: opcode constants,
// instruction class enum and the one-hot class flag struct.
package try_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_RTYPE  = 3'd1,
    CLS_IMM    = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_BRANCH = 3'd5,
    CLS_JUMP   = 3'd6
  } class_e;

  typedef struct packed {
    logic rtype;
    logic imm;
    logic load;
    logic store;
    logic branch;
    logic jump;
  } flags_t;

  // One-hot expansion; CLS_NONE yields all-zero flags.
  function automatic flags_t class_to_flags(input class_e cls);
    flags_t f;
    f = '0;
    case (cls)
      CLS_RTYPE:  f.rtype  = 1'b1;
      CLS_IMM:    f.imm    = 1'b1;
      CLS_LOAD:   f.load   = 1'b1;
      CLS_STORE:  f.store  = 1'b1;
      CLS_BRANCH: f.branch = 1'b1;
      CLS_JUMP:   f.jump   = 1'b1;
      default:    f        = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/try_decode.sv
// Combinational opcode -> instruction class decoder. Anything outside the
// supported P5 set maps to CLS_NONE.
module try_decode
  import try_pkg::*;
(
  input  logic [OP_W-1:0] op_i,
  output class_e          cls_o
);

  always_comb begin
    cls_o = CLS_NONE;
    case (op_i)
      OP_RTYPE:                 cls_o = CLS_RTYPE;
      OP_ORI, OP_LUI, OP_ADDIU: cls_o = CLS_IMM;
      OP_LW:                    cls_o = CLS_LOAD;
      OP_SW:                    cls_o = CLS_STORE;
      OP_BEQ:                   cls_o = CLS_BRANCH;
      OP_J, OP_JAL:             cls_o = CLS_JUMP;
      default:                  cls_o = CLS_NONE;
    endcase
  end

endmodule

// File: rtl/try_core.sv
// Registered MIPS primary-opcode classifier. Optional saturating illegal-opcode
// counter is built when TRY_ILLEGAL_CNT_EN is defined.
module try_core
  import try_pkg::*;
#(
  parameter int OPW  = 6,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [OPW-1:0]  A,
  output logic            B,
  output logic            is_rtype,
  output logic            is_imm,
  output logic            is_load,
  output logic            is_store,
  output logic            is_branch,
  output logic            is_jump
`ifdef TRY_ILLEGAL_CNT_EN
  ,
  output logic [CNTW-1:0] illegal_cnt
`endif
);

  // No handshake: every edge with en=1 accepts A; outputs hold while en=0.
  class_e cls;
  flags_t flags_d, flags_q;
  logic   b_d, b_q;

  try_decode u_decode (
    .op_i  (A),
    .cls_o (cls)
  );

  always_comb begin
    flags_d = flags_q;
    b_d     = b_q;
    if (en) begin
      flags_d = class_to_flags(cls);
      b_d     = (cls != CLS_NONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= '0;
      b_q     <= 1'b0;
    end else begin
      flags_q <= flags_d;
      b_q     <= b_d;
    end
  end

  assign B         = b_q;
  assign is_rtype  = flags_q.rtype;
  assign is_imm    = flags_q.imm;
  assign is_load   = flags_q.load;
  assign is_store  = flags_q.store;
  assign is_branch = flags_q.branch;
  assign is_jump   = flags_q.jump;

`ifdef TRY_ILLEGAL_CNT_EN
  logic [CNTW-1:0] cnt_d, cnt_q;

  // Saturate at all-ones rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (en && (cls == CLS_NONE) && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign illegal_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_try_core.sv
// Scoreboard bench for try_core: driver pushes model expectations, a negedge
// monitor pops and compares. Honours TRY_ILLEGAL_CNT_EN.
module tb_try_core;

  localparam int CNTW = 8;
`ifdef TRY_ILLEGAL_CNT_EN
  localparam int W = 7 + CNTW;
`else
  localparam int W = 7;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [5:0]      A;
  logic            B;
  logic            is_rtype, is_imm, is_load, is_store, is_branch, is_jump;
`ifdef TRY_ILLEGAL_CNT_EN
  logic [CNTW-1:0] illegal_cnt;
`endif

  try_core #(.OPW(6), .CNTW(CNTW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .A           (A),
    .B           (B),
    .is_rtype    (is_rtype),
    .is_imm      (is_imm),
    .is_load     (is_load),
    .is_store    (is_store),
    .is_branch   (is_branch),
    .is_jump     (is_jump)
`ifdef TRY_ILLEGAL_CNT_EN
    ,
    .illegal_cnt (illegal_cnt)
`endif
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    A     = 6'd0;
  end

  // Reference model: opcode -> class index (1=rtype .. 6=jump), counter value
  int cls_of[int];
  int m_cls;
  int m_cnt;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  function automatic logic [W-1:0] model_vec(input int cls, input int cnt);
    logic [6:0]      top;
    logic [CNTW-1:0] c;
    top = '0;
    if (cls != 0) begin
      top[6]       = 1'b1;
      top[6 - cls] = 1'b1;
    end
    c = cnt[CNTW-1:0];
`ifdef TRY_ILLEGAL_CNT_EN
    return {top, c};
`else
    if (c == '1) top = top;
    return top;
`endif
  endfunction

  function automatic logic [W-1:0] dut_vec();
`ifdef TRY_ILLEGAL_CNT_EN
    return {B, is_rtype, is_imm, is_load, is_store, is_branch, is_jump, illegal_cnt};
`else
    return {B, is_rtype, is_imm, is_load, is_store, is_branch, is_jump};
`endif
  endfunction

  // Driver: apply inputs away from the active edge, then advance the model
  task automatic step(input logic r, input logic e, input logic [5:0] a);
    @(negedge clk);
    rst_n = r;
    en    = e;
    A     = a;
    @(posedge clk);
    if (!r) begin
      m_cls = 0;
      m_cnt = 0;
    end else if (e) begin
      if (cls_of.exists(int'(a))) begin
        m_cls = cls_of[int'(a)];
      end else begin
        m_cls = 0;
        if (m_cnt < (1 << CNTW) - 1) m_cnt = m_cnt + 1;
      end
    end
    exp_q.push_back(model_vec(m_cls, m_cnt));
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = dut_vec();
      checks++;
      if (act_v === exp_v) passes++;
      else $display("FAIL outputs t=%0t A=%b: got %h expected %h", $time, A, act_v, exp_v);
    end
  end

  initial begin
    logic [5:0] sup [9];
    cls_of[6'b000000] = 1;
    cls_of[6'b001101] = 2;
    cls_of[6'b001111] = 2;
    cls_of[6'b001001] = 2;
    cls_of[6'b100011] = 3;
    cls_of[6'b101011] = 4;
    cls_of[6'b000100] = 5;
    cls_of[6'b000010] = 6;
    cls_of[6'b000011] = 6;
    sup = '{6'b000000, 6'b001101, 6'b001111, 6'b001001, 6'b100011,
            6'b101011, 6'b000100, 6'b000010, 6'b000011};
    m_cls = 0;
    m_cnt = 0;

    // Reset for two edges, then first classification
    step(1'b0, 1'b1, 6'd0);
    step(1'b0, 1'b1, 6'd0);
    step(1'b1, 1'b1, 6'd0);

    // Full opcode sweep
    for (int i = 0; i < 64; i++) step(1'b1, 1'b1, 6'(i));
`ifdef TRY_ILLEGAL_CNT_EN
    @(negedge clk);
    #1;
    checks++;
    if (illegal_cnt == 8'd55) passes++;
    else $display("FAIL sweep_cnt: got %0d expected 55", illegal_cnt);
`endif

    // Hold while disabled
    step(1'b1, 1'b1, 6'b101011);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 6'b111111);

    // Saturation
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 6'b111111);

    // Mid-stream reset
    step(1'b1, 1'b1, 6'b000100);
    step(1'b0, 1'b1, 6'b001101);
    step(1'b1, 1'b1, 6'b001101);

    // Randomized traffic, biased toward supported opcodes
    for (int i = 0; i < 500; i++) begin
      logic [5:0] a;
      logic       e;
      logic       r;
      a = ($urandom_range(0, 1) == 0) ? sup[$urandom_range(0, 8)] : 6'($urandom_range(0, 63));
      e = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 24) != 0);
      step(r, e, a);
    end

    // Drain: every expectation must have been consumed
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/try_core.md
# try_core

Registered MIPS primary-opcode classifier for the P5 pipelined CPU decode stage. It samples the 6-bit opcode field `A` (instr[31:26]) and reports on `B` whether the opcode belongs to the supported P5 instruction set. It also provides one-hot class flags consumed by the hazard and control logic. Output is registered: one-cycle latency, hold when not enabled.

## Interface
- `OPW`, default 6: opcode width; fixed at 6 and not meant to be overridden.
- `CNTW`, default 8: width of the illegal-opcode counter.

- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `en` input 1: sample enable; when 1, `A` is classified at this edge.
- `A` input 6: opcode field to classify.
- `B` output 1: 1 if the last sampled opcode is supported.
- `is_rtype` output 1: last sample was R-type (000000).
- `is_imm` output 1: last sample was ALU-immediate (ori, lui, addiu).
- `is_load` output 1: last sample was lw.
- `is_store` output 1: last sample was sw.
- `is_branch` output 1: last sample was beq.
- `is_jump` output 1: last sample was j or jal.
- `illegal_cnt` output CNTW: saturating count of unsupported opcodes sampled. Present only with the macro.

## Operation
- Supported opcodes:
  - 000000 R-type
  - 001101 ori
  - 001111 lui
  - 001001 addiu
  - 100011 lw
  - 101011 sw
  - 000100 beq
  - 000010 j
  - 000011 jal
- Any other value is unsupported.
- `B` = 1 exactly when exactly one class flag is 1; class flags are mutually exclusive.
- Unsupported opcode: `B` and all class flags are 0.
- `en` = 0: all outputs hold their previous registered values.
- Classification is pure decode of `A`; no other inputs affect it.
- Counter (macro enabled): increments by 1 on each enabled edge with an unsupported `A`. Saturates at 2^CNTW-1. Supported opcodes leave it unchanged.

## Timing
- Reset: on a rising edge with `rst_n` = 0, `B`, all flags and `illegal_cnt` become 0. Reset overrides `en`.
- Latency: `A` sampled at edge N (with `en` = 1) is visible on outputs after edge N, stable until the next enabled edge.
- Reset asserted mid-stream clears outputs at that edge. The first classification after release needs one enabled edge.
- No handshake and no backpressure; throughput is one opcode per cycle.
- Outputs are glitch-free (registered); no combinational path from `A` to outputs.

## Configuration
- Macro `TRY_ILLEGAL_CNT_EN`:
  - Defined: `illegal_cnt` port and counter logic exist, behaving as above.
  - Undefined: port and logic are absent; all other behaviour is identical.

## Structure
- Shared package `try_pkg`:
  - opcode localparams (`OP_RTYPE`, `OP_ORI`, `OP_LUI`, `OP_ADDIU`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_J`, `OP_JAL`)
  - 3-bit class enum `class_e` (NONE, RTYPE, IMM, LOAD, STORE, BRANCH, JUMP)
- One sub-module, `try_decode`: combinational `A` → `class_e`.
- The top level contains the registers, one-hot expansion, `B` derivation and the optional counter.

## Test plan
- Hold `rst_n` = 0 for 2 edges with `A` = 0, `en` = 1 → all outputs 0. `illegal_cnt` = 0 if enabled.
- Release reset with `A` = 000000, `en` = 1 → one edge later `B` = 1, `is_rtype` = 1, other flags 0.
- Sweep `A` over all 64 values, one per cycle, with `en` = 1:
  - exactly 9 values give `B` = 1, each with the correct single class flag;
  - 100011 → `is_load`, 000011 → `is_jump`;
  - with the macro, `illegal_cnt` = 55 afterwards.
- Set `A` = 101011 with `en` = 1, then change `A` to 111111 with `en` = 0 for 3 cycles → `B` = 1 and `is_store` = 1 held throughout; counter unchanged.
- Apply unsupported `A` = 111111 for 300 enabled cycles, macro enabled, CNTW = 8 → `illegal_cnt` saturates at 255.
- Assert `rst_n` = 0 for one edge mid-stream while `A` = 001101 → outputs 0 after that edge. The next enabled edge gives `B` = 1, `is_imm` = 1.
